split_view_mux: RTL



---
 rtl/split_view_mux.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/split_view_mux.sv
// split_view_mux: filtered / original / split-screen selector ahead of hdmi_tx.
// Define SPLIT_VIEW_MARKER_EN to draw a white column at the split boundary.
module split_view_mux #(
    parameter int DELAY  = 2100,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       y_i,
    input  logic             dv_i,
    input  logic [7:0]       r_f,
    input  logic [7:0]       g_f,
    input  logic [7:0]       b_f,
    input  logic             dv_f,
    input  logic             hs_f,
    input  logic             vs_f,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] split_x_i,
    output logic [7:0]       r_o,
    output logic [7:0]       g_o,
    output logic [7:0]       b_o,
    output logic             dv_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic [CNT_W-1:0] hcnt_o,
    output logic [CNT_W-1:0] vcnt_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int FILL_W = $clog2(DELAY + 1);
    localparam logic [ADDR_W-1:0] RD_OFS = ADDR_W'(DELAY - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DELAY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Delay buffer: synchronous read one cycle ahead of use
    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [8:0]        rd_q;
    logic [FILL_W-1:0] fill;
    logic              full;
    logic [7:0]        yd;
    logic              unused_dv;

    assign rd_addr   = wr_ptr - RD_OFS;
    assign full      = (fill == FILL_FULL);
    assign yd        = full ? rd_q[7:0] : 8'd0;
    assign unused_dv = rd_q[8];

    always_ff @(posedge clk) begin
        mem[wr_ptr] <= {dv_i, y_i};
        rd_q        <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (!full) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    // Edge detection uses the registered timing outputs as the previous sample
    logic dv_fall;
    logic vs_rise;

    assign dv_fall = !dv_f && dv_o;
    assign vs_rise = vs_f && !vs_o;

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [1:0]       mode_s;
    logic [CNT_W-1:0] split_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
        end else if (dv_f) begin
            if (hcnt != CNT_MAX) begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end else if (dv_fall) begin
            hcnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vcnt <= '0;
        end else if (vs_rise) begin
            vcnt <= '0;
        end else if (dv_fall && vcnt != CNT_MAX) begin
            vcnt <= vcnt + CNT_W'(1);
        end
    end

    // View settings only change at frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_s  <= 2'd0;
            split_s <= '0;
        end else if (vs_rise) begin
            mode_s  <= mode_i;
            split_s <= split_x_i;
        end
    end

    logic [23:0] filt;
    logic [23:0] orig;
    logic [23:0] pix;
    logic        show_orig;
    logic        marker;

    assign filt = {r_f, g_f, b_f};
    assign orig = {yd, yd, yd};

    always_comb begin
        show_orig = 1'b0;
        marker    = 1'b0;
        pix       = '0;
        unique case (mode_s)
            2'd1:    show_orig = 1'b1;
            2'd2:    show_orig = (hcnt >= split_s);
            default: show_orig = 1'b0;
        endcase
`ifdef SPLIT_VIEW_MARKER_EN
        marker = (mode_s == 2'd2) && (hcnt == split_s);
`endif
        if (!dv_f) begin
            pix = '0;
        end else if (marker) begin
            pix = '1;
        end else if (show_orig) begin
            pix = orig;
        end else begin
            pix = filt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o    <= '0;
            g_o    <= '0;
            b_o    <= '0;
            dv_o   <= 1'b0;
            hs_o   <= 1'b0;
            vs_o   <= 1'b0;
            hcnt_o <= '0;
            vcnt_o <= '0;
        end else begin
            {r_o, g_o, b_o} <= pix;
            dv_o   <= dv_f;
            hs_o   <= hs_f;
            vs_o   <= vs_f;
            hcnt_o <= hcnt;
            vcnt_o <= vcnt;
        end
    end

endmodule
